// File: rtl/risc_loader_pkg.sv
// Shared types and constants for the RISC program loader.
package risc_loader_pkg;

  // Loader FSM: LOAD accepts host commands, COMMIT writes one word, RUN lets the core execute.
  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // host_sel command codes (2'b11 is reserved and ignored).
  localparam logic [1:0] SEL_ADDR = 2'b00;
  localparam logic [1:0] SEL_DATA = 2'b01;
  localparam logic [1:0] SEL_CTRL = 2'b10;

  // CTRL payload bit positions.
  localparam int CTRL_RUN = 0;
  localparam int CTRL_CLR = 1;

  // status bit positions.
  localparam int STAT_RUN     = 0;
  localparam int STAT_PARTIAL = 1;
  localparam int STAT_ERR     = 2;
  localparam int STAT_WRAP    = 3;

endpackage

// File: rtl/risc_pin_sync.sv
// Two-flop synchroniser for an asynchronous pin followed by a rising-edge
// detector. All flops reset to RST_VAL so a pin already high at reset
// release does not look like a fresh edge.
module risc_pin_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  // Synchronise the pin and keep the previous synchronised value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= RST_VAL;
      sync2_reg <= RST_VAL;
      prev_reg  <= RST_VAL;
    end else begin
      sync1_reg <= pin;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign pulse = sync2_reg & ~prev_reg;

endmodule

// File: rtl/risc_prog_loader.sv
// Program loader: turns strobed host commands into instruction-memory
// writes, assembling multi-byte words little-endian, auto-incrementing the
// load address and holding the core stopped until an explicit run command.
module risc_prog_loader
  import risc_loader_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int INSTR_BYTES = 2,
  parameter int ADDR_W      = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          host_we,
  input  logic [1:0]                    host_sel,
  input  logic [DATA_W-1:0]             host_data,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W*INSTR_BYTES-1:0] mem_wdata,
  output logic                          cpu_run,
  output logic [ADDR_W:0]               word_count,
  output logic [3:0]                    status
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int WORD_W = DATA_W * INSTR_BYTES;
  localparam int CNT_W  = ADDR_W + 1;
  localparam int IDX_W  = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(INSTR_BYTES - 1);
  localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(DEPTH);

  logic strobe;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    index_reg, index_next;
  logic [ADDR_W-1:0]   addr_reg,  addr_next;
  logic [WORD_W-1:0]   wdata_reg, wdata_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic                err_reg,   err_next;
  logic                wrap_reg,  wrap_next;

  logic                   byte_load;
  logic [INSTR_BYTES-1:0] slot_we;
  logic [WORD_W-1:0]      asm_word;

  risc_pin_sync #(
    .RST_VAL (1'b1)
  ) u_we_sync (
    .clk   (clk),
    .rst   (rst),
    .pin   (host_we),
    .pulse (strobe)
  );

  // One assembly slot per byte; asm_word shows the byte being written this
  // cycle so the final byte can be captured into mem_wdata in the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < INSTR_BYTES; gi++) begin : g_slot
      logic [DATA_W-1:0] slot_reg;

      assign slot_we[gi] = byte_load && (index_reg == IDX_W'(gi));

      // Capture the host byte into this slot when it is the current index.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_reg <= '0;
        end else if (slot_we[gi]) begin
          slot_reg <= host_data;
        end
      end

      assign asm_word[gi*DATA_W +: DATA_W] = slot_we[gi] ? host_data : slot_reg;
    end
  endgenerate

  // Loader state register and all architectural registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_LOAD;
      index_reg <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      count_reg <= count_next;
      err_reg   <= err_next;
      wrap_reg  <= wrap_next;
    end
  end

  // Command decode and next-state logic; CTRL clear is applied before the
  // run/stop action so a discard during run entry still leaves err set.
  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    count_next = count_reg;
    err_next   = err_reg;
    wrap_next  = wrap_reg;
    byte_load  = 1'b0;

    case (state_reg)
      ST_LOAD: begin
        if (strobe) begin
          case (host_sel)
            SEL_ADDR: begin
              addr_next  = host_data[ADDR_W-1:0];
              index_next = '0;
              if (index_reg != '0) err_next = 1'b1;
            end
            SEL_DATA: begin
              byte_load = 1'b1;
              if (index_reg == LAST_IDX) begin
                wdata_next = asm_word;
                state_next = ST_COMMIT;
              end else begin
                index_next = index_reg + 1'b1;
              end
            end
            SEL_CTRL: begin
              if (host_data[CTRL_CLR]) begin
                err_next   = 1'b0;
                wrap_next  = 1'b0;
                count_next = '0;
              end
              if (host_data[CTRL_RUN]) begin
                state_next = ST_RUN;
                index_next = '0;
                if (index_reg != '0) err_next = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      ST_COMMIT: begin
        addr_next  = addr_reg + 1'b1;
        index_next = '0;
        if (count_reg != COUNT_MAX) count_next = count_reg + 1'b1;
        if (addr_reg == '1) wrap_next = 1'b1;
        state_next = ST_LOAD;
      end

      ST_RUN: begin
        if (strobe) begin
          case (host_sel)
            SEL_ADDR, SEL_DATA: err_next = 1'b1;
            SEL_CTRL: begin
              if (host_data[CTRL_CLR]) begin
                err_next   = 1'b0;
                wrap_next  = 1'b0;
                count_next = '0;
              end
              if (!host_data[CTRL_RUN]) state_next = ST_LOAD;
            end
            default: ;
          endcase
        end
      end

      default: state_next = ST_LOAD;
    endcase
  end

  assign mem_we     = (state_reg == ST_COMMIT);
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign cpu_run    = (state_reg == ST_RUN);
  assign word_count = count_reg;

  assign status[STAT_RUN]     = cpu_run;
  assign status[STAT_PARTIAL] = (index_reg != '0);
  assign status[STAT_ERR]     = err_reg;
  assign status[STAT_WRAP]    = wrap_reg;

endmodule

// File: tb/tb_risc_prog_loader.sv
// Self-checking bench for risc_prog_loader: directed scenarios plus random
// host commands compared against a command-level reference model.
module tb_risc_prog_loader;

  localparam int DATA_W      = 8;
  localparam int INSTR_BYTES = 2;
  localparam int ADDR_W      = 7;
  localparam int DEPTH       = 2 ** ADDR_W;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          host_we;
  logic [1:0]                    host_sel;
  logic [DATA_W-1:0]             host_data;
  logic                          mem_we;
  logic [ADDR_W-1:0]             mem_addr;
  logic [DATA_W*INSTR_BYTES-1:0] mem_wdata;
  logic                          cpu_run;
  logic [ADDR_W:0]               word_count;
  logic [3:0]                    status;

  risc_prog_loader #(
    .DATA_W      (DATA_W),
    .INSTR_BYTES (INSTR_BYTES),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host_we    (host_we),
    .host_sel   (host_sel),
    .host_data  (host_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_run    (cpu_run),
    .word_count (word_count),
    .status     (status)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cmd    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_addr, m_idx, m_count, m_wdata;
  bit m_err, m_wrap, m_run;
  int m_bytes[INSTR_BYTES];
  int exp_wr_addr[$];
  int exp_wr_data[$];
  int obs_wr_addr[$];
  int obs_wr_data[$];

  task automatic model_reset();
    m_addr = 0; m_idx = 0; m_count = 0; m_wdata = 0;
    m_err = 0; m_wrap = 0; m_run = 0;
    for (int i = 0; i < INSTR_BYTES; i++) m_bytes[i] = 0;
    exp_wr_addr.delete(); exp_wr_data.delete();
    obs_wr_addr.delete(); obs_wr_data.delete();
  endtask

  task automatic model_apply(input int sel, input int data);
    int word;
    case (sel)
      0: begin
        if (m_run) m_err = 1;
        else begin
          if (m_idx != 0) m_err = 1;
          m_addr = data % DEPTH;
          m_idx  = 0;
        end
      end
      1: begin
        if (m_run) m_err = 1;
        else begin
          m_bytes[m_idx] = data % 256;
          if (m_idx == INSTR_BYTES - 1) begin
            word = 0;
            for (int i = 0; i < INSTR_BYTES; i++) word += m_bytes[i] * (1 << (8 * i));
            m_wdata = word;
            exp_wr_addr.push_back(m_addr);
            exp_wr_data.push_back(word);
            if (m_addr == DEPTH - 1) m_wrap = 1;
            m_addr  = (m_addr + 1) % DEPTH;
            m_count = (m_count < DEPTH) ? m_count + 1 : DEPTH;
            m_idx   = 0;
          end else begin
            m_idx++;
          end
        end
      end
      2: begin
        if ((data & 2) != 0) begin m_err = 0; m_wrap = 0; m_count = 0; end
        if ((data & 1) != 0 && !m_run) begin
          if (m_idx != 0) m_err = 1;
          m_idx = 0;
          m_run = 1;
        end else if ((data & 1) == 0 && m_run) begin
          m_run = 0;
        end
      end
      default: ;
    endcase
  endtask

  // Record every cycle with mem_we high; a stretched pulse shows up as extra writes.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_wr_addr.push_back(int'(mem_addr));
      obs_wr_data.push_back(int'(mem_wdata));
    end
  end

  task automatic check_all(input string tag);
    logic [3:0] exp_status;
    exp_status = {m_wrap, m_err, (m_idx != 0), m_run};
    check({tag, ".mem_we"}, mem_we, 0);
    check({tag, ".addr"}, mem_addr, m_addr);
    check({tag, ".count"}, word_count, m_count);
    check({tag, ".status"}, status, exp_status);
    check({tag, ".run"}, cpu_run, m_run);
    check({tag, ".wdata"}, mem_wdata, m_wdata);
    check({tag, ".nwr"}, obs_wr_addr.size(), exp_wr_addr.size());
    while (obs_wr_addr.size() > 0 && exp_wr_addr.size() > 0) begin
      check({tag, ".wr_addr"}, obs_wr_addr.pop_front(), exp_wr_addr.pop_front());
      check({tag, ".wr_data"}, obs_wr_data.pop_front(), exp_wr_data.pop_front());
    end
    exp_wr_addr.delete(); exp_wr_data.delete();
    obs_wr_addr.delete(); obs_wr_data.delete();
  endtask

  // One full host command: strobe high for 3 cycles, low for 4.
  task automatic do_cmd(input int sel, input int data);
    @(negedge clk);
    host_sel  = 2'(sel);
    host_data = 8'(data);
    host_we   = 1'b1;
    repeat (3) @(negedge clk);
    host_we = 1'b0;
    repeat (4) @(negedge clk);
    model_apply(sel, data);
    n_cmd++;
    $display("cmd %0d sel=%0d data=0x%02h addr=0x%02h cnt=%0d status=%04b",
             n_cmd, sel, data & 255, mem_addr, word_count, status);
    check_all($sformatf("cmd%0d", n_cmd));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int r, sel, data;
    rst = 1'b1; host_we = 1'b0; host_sel = 2'b00; host_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.mem_we", mem_we, 0);
    check("reset.addr", mem_addr, 0);
    check("reset.wdata", mem_wdata, 0);
    check("reset.run", cpu_run, 0);
    check("reset.count", word_count, 0);
    check("reset.status", status, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic word load
    do_cmd(0, 8'h10); do_cmd(1, 8'h34); do_cmd(1, 8'h12);
    check("t1.addr", mem_addr, 7'h11);
    check("t1.wdata", mem_wdata, 16'h1234);
    check("t1.status", status, 4'b0000);

    // Wrap at the top of memory
    do_cmd(0, 8'h7F); do_cmd(1, 8'h01); do_cmd(1, 8'h02); do_cmd(1, 8'h03); do_cmd(1, 8'h04);
    check("t2.status", status, 4'b1000);
    check("t2.count", word_count, 3);

    // Partial word discarded by ADDR
    do_cmd(1, 8'hAA); do_cmd(0, 8'h05);
    check("t3.status", status, 4'b1100);
    check("t3.addr", mem_addr, 7'h05);

    // Run, rejected data, clear+stop
    do_cmd(2, 8'h01); do_cmd(1, 8'h55); do_cmd(2, 8'h02);
    check("t4.status", status, 4'b0000);
    check("t4.count", word_count, 0);

    // Random commands
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin sel = 0; data = $urandom_range(0, 255); end
      else if (r < 7) begin sel = 1; data = $urandom_range(0, 255); end
      else if (r < 9) begin sel = 2; data = $urandom_range(0, 3); end
      else begin sel = 3; data = $urandom_range(0, 255); end
      do_cmd(sel, data);
    end

    // host_we held high across reset release produces no strobe
    @(negedge clk);
    host_sel = 2'b00; host_data = 8'h22; host_we = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check_all("held");
    host_we = 1'b0;
    repeat (3) @(negedge clk);
    host_we = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("edge.n1_addr", mem_addr, 0);
    @(posedge clk); #1;
    check("edge.n2_addr", mem_addr, 7'h22);
    @(negedge clk); host_we = 1'b0;
    repeat (4) @(negedge clk);
    model_apply(0, 8'h22);
    check_all("edge");

    // Reset asserted in the COMMIT cycle
    do_cmd(1, 8'h78);
    @(negedge clk);
    host_sel = 2'b01; host_data = 8'h56; host_we = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    check("commit.mem_we", mem_we, 1);
    check("commit.addr", mem_addr, 7'h22);
    check("commit.wdata", mem_wdata, 16'h5678);
    rst = 1'b1;
    #1;
    check("rstc.mem_we", mem_we, 0);
    check("rstc.addr", mem_addr, 0);
    check("rstc.wdata", mem_wdata, 0);
    check("rstc.status", status, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    host_we = 1'b0;
    repeat (5) @(negedge clk);
    check_all("rstc");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
